// File: rtl/axi_lite_master_bridge.sv
// AXI-Lite initiator: turns single-beat local commands into AXI-Lite reads/writes
// and returns the slave response over a local valid/ready handshake. 32-bit data only.
module axi_lite_master_bridge #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,

    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_offset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_we,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              rsp_we,

    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [2:0]                        M_AXI_AWPROT,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic [2:0]                        M_AXI_ARPROT,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam int unsigned ADDR_W = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DATA_W = C_M_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t              r_state;
    logic                r_cmd_ready;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic                r_we;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_rdata;
    logic [1:0]          r_rsp_resp;

    // A channel counts as done once its VALID has dropped or it handshakes this cycle.
    logic w_aw_done;
    logic w_w_done;
    assign w_aw_done = !r_awvalid || M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid  || M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_we        <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_resp  <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // cmd_ready is registered, so the first cycle after reset never accepts
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_addr      <= ADDR_W'(cmd_addr + base_offset);
                        r_wdata     <= cmd_wdata;
                        r_wstrb     <= cmd_wstrb;
                        r_we        <= cmd_we;
                        if (cmd_we) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WRITE;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
                    if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (M_AXI_BVALID) begin
                        r_bready    <= 1'b0;
                        r_rsp_resp  <= M_AXI_BRESP;
                        r_rsp_rdata <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RADDR: begin
                    if (M_AXI_ARREADY) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (M_AXI_RVALID) begin
                        r_rready    <= 1'b0;
                        r_rsp_rdata <= M_AXI_RDATA;
                        r_rsp_resp  <= M_AXI_RRESP;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_rdata     = r_rsp_rdata;
    assign rsp_resp      = r_rsp_resp;
    assign rsp_we        = r_we;

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_AWPROT  = 3'b000;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_BREADY  = r_bready;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARVALID = r_arvalid;
    assign M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Directed bench for axi_lite_master_bridge: the slave side is driven by hand,
// cycle by cycle, with expected values worked out per scenario.
module tb_axi_lite_master_bridge;

    logic        M_AXI_ACLK;
    logic        M_AXI_ARESET;
    logic [31:0] base_offset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_we;
    logic [31:0] M_AXI_AWADDR;
    logic [2:0]  M_AXI_AWPROT;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic [2:0]  M_AXI_ARPROT;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;

    int checks   = 0;
    int failures = 0;
    int b_hs     = 0;

    axi_lite_master_bridge #(.C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32)) dut (
        .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
        .base_offset(base_offset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_we(rsp_we),
        .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWPROT(M_AXI_AWPROT),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    initial M_AXI_ACLK = 1'b0;
    always #5 M_AXI_ACLK = ~M_AXI_ACLK;

    // Count accepted B beats independently of the bench tasks.
    always @(posedge M_AXI_ACLK) if (M_AXI_BREADY && M_AXI_BVALID) b_hs++;

    task automatic tick();
        @(posedge M_AXI_ACLK);
        #1;
    endtask

    task automatic put_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] wstrb);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
    endtask

    task automatic test_reset();
        M_AXI_ARESET = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_we, rsp_resp, M_AXI_AWVALID, M_AXI_WVALID,
             M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 10'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0", {cmd_ready, rsp_valid, rsp_we, rsp_resp,
                     M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
        end
        checks++;
        if ({M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, M_AXI_WSTRB, rsp_rdata,
             M_AXI_AWPROT, M_AXI_ARPROT} !== 138'b0) begin
            failures++;
            $display("FAIL reset_data awaddr=%h araddr=%h wdata=%h rdata=%h exp=0",
                     M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA, rsp_rdata);
        end
        M_AXI_ARESET = 1'b0;
        tick();
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        int b0;
        b0 = b_hs;
        base_offset = 32'h4000_0000;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b00;
        put_cmd(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, M_AXI_BREADY} !== 4'b1100) begin
            failures++;
            $display("FAIL wr_issue aw/w/cready/bready got=%b exp=1100",
                     {M_AXI_AWVALID, M_AXI_WVALID, cmd_ready, M_AXI_BREADY});
        end
        checks++;
        if ({M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB} !== {32'h4000_0008, 32'hDEAD_BEEF, 4'hF}) begin
            failures++;
            $display("FAIL wr_payload got=%h/%h/%h exp=40000008/deadbeef/f",
                     M_AXI_AWADDR, M_AXI_WDATA, M_AXI_WSTRB);
        end
        tick();
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid} !== 4'b0010) begin
            failures++;
            $display("FAIL wr_wresp aw/w/bready/rvalid got=%b exp=0010",
                     {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, rsp_valid});
        end
        tick();
        checks++;
        if ({M_AXI_BREADY, rsp_valid, rsp_we, rsp_resp, rsp_rdata} !== {5'b01100, 32'h0}) begin
            failures++;
            $display("FAIL wr_rsp bready/valid/we/resp/rdata got=%b/%b/%b/%b/%h exp=0/1/1/00/0",
                     M_AXI_BREADY, rsp_valid, rsp_we, rsp_resp, rsp_rdata);
        end
        checks++;
        if (b_hs - b0 !== 1) begin
            failures++;
            $display("FAIL wr_b_count got=%0d exp=1", b_hs - b0);
        end
        M_AXI_BVALID = 1'b0; M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            failures++;
            $display("FAIL wr_done valid/cready got=%b exp=01", {rsp_valid, cmd_ready});
        end
    endtask

    task automatic test_read_waits();
        base_offset = 32'h4000_0000;
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0;
        put_cmd(1'b0, 32'h10, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) M_AXI_ARREADY = 1'b1;
            checks++;
            if ({M_AXI_ARVALID, M_AXI_RREADY, cmd_ready, M_AXI_ARADDR} !== {3'b100, 32'h4000_0010}) begin
                failures++;
                $display("FAIL rd_ar_hold cyc=%0d arvalid/rready/cready=%b araddr=%h exp=100/40000010",
                         i, {M_AXI_ARVALID, M_AXI_RREADY, cmd_ready}, M_AXI_ARADDR);
            end
            tick();
        end
        M_AXI_ARREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({M_AXI_ARVALID, M_AXI_RREADY, rsp_valid} !== 3'b010) begin
                failures++;
                $display("FAIL rd_r_wait cyc=%0d arvalid/rready/rvalid got=%b exp=010",
                         i, {M_AXI_ARVALID, M_AXI_RREADY, rsp_valid});
            end
            tick();
        end
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h1234_5678; M_AXI_RRESP = 2'b10;
        tick();
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00;
        checks++;
        if ({rsp_valid, M_AXI_RREADY, rsp_we, rsp_resp, rsp_rdata} !== {5'b10010, 32'h1234_5678}) begin
            failures++;
            $display("FAIL rd_rsp valid/rready/we/resp/rdata got=%b/%b/%b/%b/%h exp=1/0/0/10/12345678",
                     rsp_valid, M_AXI_RREADY, rsp_we, rsp_resp, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_split_write(input bit w_first, input logic [1:0] bresp);
        int b0;
        logic [2:0] exp_first;
        exp_first = w_first ? 3'b100 : 3'b010;
        base_offset = 32'h0;
        put_cmd(1'b1, 32'h100, 32'hA5A5_0F0F, 4'h3);
        tick();
        cmd_valid = 1'b0;
        M_AXI_WREADY = w_first; M_AXI_AWREADY = !w_first;
        tick();
        M_AXI_WREADY = 1'b0; M_AXI_AWREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== exp_first) begin
                failures++;
                $display("FAIL split_partial wfirst=%0d cyc=%0d aw/w/bready got=%b exp=%b",
                         w_first, i, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, exp_first);
            end
            if (i == 1) begin
                M_AXI_WREADY = !w_first; M_AXI_AWREADY = w_first;
            end
            tick();
        end
        M_AXI_WREADY = 1'b0; M_AXI_AWREADY = 1'b0;
        checks++;
        if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY} !== 3'b001) begin
            failures++;
            $display("FAIL split_both wfirst=%0d aw/w/bready got=%b exp=001",
                     w_first, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY});
        end
        b0 = b_hs;
        M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp;
        tick();
        tick();
        M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        checks++;
        if ({rsp_valid, M_AXI_BREADY, rsp_resp} !== {2'b10, bresp} || b_hs - b0 !== 1) begin
            failures++;
            $display("FAIL split_b wfirst=%0d valid/bready/resp=%b/%b/%b bcount=%0d exp=1/0/%b/1",
                     w_first, rsp_valid, M_AXI_BREADY, rsp_resp, b_hs - b0, bresp);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_addr_wrap();
        base_offset = 32'hFFFF_FFF0;
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_BVALID = 1'b1; M_AXI_BRESP = 2'b01;
        put_cmd(1'b1, 32'h20, 32'h0000_0001, 4'h1);
        tick();
        cmd_valid = 1'b0;
        checks++;
        if (M_AXI_AWADDR !== 32'h0000_0010) begin
            failures++;
            $display("FAIL wrap_awaddr got=%h exp=00000010", M_AXI_AWADDR);
        end
        tick();
        tick();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00;
        checks++;
        if ({rsp_valid, rsp_resp} !== 3'b101) begin
            failures++;
            $display("FAIL wrap_rsp valid/resp got=%b exp=101", {rsp_valid, rsp_resp});
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        base_offset = 32'h1000_0000;
        M_AXI_ARREADY = 1'b1;
        put_cmd(1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        put_cmd(1'b1, 32'h44, 32'h7777_8888, 4'hC);
        tick();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hCAFE_F00D; M_AXI_RRESP = 2'b11;
        tick();
        M_AXI_RVALID = 1'b0; M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({rsp_valid, cmd_ready, M_AXI_AWVALID, M_AXI_ARVALID, rsp_resp, rsp_rdata}
                    !== {6'b100011, 32'hCAFE_F00D}) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d valid/cready/aw/ar=%b resp=%b rdata=%h exp=1000/11/cafef00d",
                         i, {rsp_valid, cmd_ready, M_AXI_AWVALID, M_AXI_ARVALID}, rsp_resp, rsp_rdata);
            end
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, cmd_ready, M_AXI_AWVALID} !== 3'b010) begin
            failures++;
            $display("FAIL bp_release valid/cready/aw got=%b exp=010",
                     {rsp_valid, cmd_ready, M_AXI_AWVALID});
        end
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({cmd_ready, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_AWADDR} !== {3'b011, 32'h1000_0044}) begin
            failures++;
            $display("FAIL bp_accept cready/aw/w=%b awaddr=%h exp=011/10000044",
                     {cmd_ready, M_AXI_AWVALID, M_AXI_WVALID}, M_AXI_AWADDR);
        end
        M_AXI_AWREADY = 1'b1; M_AXI_WREADY = 1'b1;
        tick();
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b1;
        tick();
        M_AXI_BVALID = 1'b0;
        checks++;
        if ({rsp_valid, rsp_we, rsp_resp, rsp_rdata} !== {4'b1100, 32'h0}) begin
            failures++;
            $display("FAIL bp_wr_rsp valid/we/resp=%b rdata=%h exp=1100/0",
                     {rsp_valid, rsp_we, rsp_resp}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        base_offset = 32'h0;
        M_AXI_ARREADY = 1'b1;
        put_cmd(1'b0, 32'h80, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        M_AXI_ARREADY = 1'b0;
        checks++;
        if (M_AXI_RREADY !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_in_rdata rready got=%b exp=1", M_AXI_RREADY);
        end
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'hFFFF_FFFF; M_AXI_RRESP = 2'b11;
        M_AXI_ARESET = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, rsp_resp, M_AXI_RREADY, M_AXI_ARVALID, M_AXI_ARADDR, rsp_rdata}
                !== 70'b0) begin
            failures++;
            $display("FAIL rst_mid_outputs cready/valid/resp/rready/ar=%b araddr=%h rdata=%h exp=0",
                     {cmd_ready, rsp_valid, rsp_resp, M_AXI_RREADY, M_AXI_ARVALID}, M_AXI_ARADDR, rsp_rdata);
        end
        M_AXI_ARESET = 1'b0;
        M_AXI_BVALID = 1'b1;
        tick();
        checks++;
        if ({cmd_ready, rsp_valid, M_AXI_BREADY, M_AXI_RREADY} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_idle cready/valid/bready/rready got=%b exp=1000",
                     {cmd_ready, rsp_valid, M_AXI_BREADY, M_AXI_RREADY});
        end
        M_AXI_BVALID = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RRESP = 2'b00;
        M_AXI_ARREADY = 1'b1;
        put_cmd(1'b0, 32'h84, 32'h0, 4'h0);
        tick();
        cmd_valid = 1'b0;
        tick();
        M_AXI_ARREADY = 1'b0;
        M_AXI_RVALID = 1'b1; M_AXI_RDATA = 32'h0BAD_F00D;
        tick();
        M_AXI_RVALID = 1'b0;
        checks++;
        if ({rsp_valid, rsp_resp, rsp_rdata} !== {3'b100, 32'h0BAD_F00D}) begin
            failures++;
            $display("FAIL rst_mid_next_read valid/resp=%b rdata=%h exp=100/0badf00d",
                     {rsp_valid, rsp_resp}, rsp_rdata);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        M_AXI_ARESET = 1'b1;
        base_offset = 32'h0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0;
        M_AXI_BRESP = 2'b00; M_AXI_BVALID = 1'b0;
        M_AXI_ARREADY = 1'b0;
        M_AXI_RDATA = 32'h0; M_AXI_RRESP = 2'b00; M_AXI_RVALID = 1'b0;

        test_reset();
        test_write_zero_wait();
        test_read_waits();
        test_split_write(1'b1, 2'b10);
        test_split_write(1'b0, 2'b11);
        test_addr_wrap();
        test_backpressure();
        test_reset_mid_read();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
